// File: rtl/traffic_light_ctrl_p.sv
// Highway/farm-road intersection controller with tick prescaler, min/max farm green,
// latched pedestrian request and night flash mode. Lamps and walk are registered from next state.
module traffic_light_ctrl_p #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned G_MIN_H  = 10,
    parameter int unsigned Y_T      = 3,
    parameter int unsigned AR_T     = 1,
    parameter int unsigned F_MIN    = 5,
    parameter int unsigned F_MAX    = 20,
    parameter int unsigned FLASH_T  = 4
) (
    input  logic       clk_125M,
    input  logic       rst_n,
    input  logic       c,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] HL,
    output logic [2:0] FL,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        S_HG    = 3'd0,
        S_HY    = 3'd1,
        S_AR1   = 3'd2,
        S_FG    = 3'd3,
        S_FY    = 3'd4,
        S_AR2   = 3'd5,
        S_FLASH = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   elapsed, e_now, e_nxt;
    logic [PRE_W-1:0]   presc, presc_nxt;
    logic               tick;
    logic               flash_on, flash_on_nxt;
    logic               ped_pending, ped_pending_nxt;
    logic               c_meta, c_s;
    logic [2:0]         hl_nxt, fl_nxt;

    // Next-state, counter and lamp decode
    always_comb begin
        tick            = (presc == PRE_W'(TICK_DIV - 1));
        presc_nxt       = tick ? '0 : presc + 1'b1;
        e_now           = elapsed;
        if (tick && (elapsed != {CNT_W{1'b1}})) begin
            e_now = elapsed + 1'b1;
        end
        e_nxt           = e_now;
        state_nxt       = state;
        flash_on_nxt    = flash_on;
        hl_nxt          = LAMP_R;
        fl_nxt          = LAMP_R;

        case (state)
            S_HG: begin
                if (night) begin
                    state_nxt = S_FLASH;
                end else if ((e_now >= CNT_W'(G_MIN_H)) && (c_s || ped_pending)) begin
                    state_nxt = S_HY;
                end
            end
            S_HY:  if (e_now >= CNT_W'(Y_T))  state_nxt = S_AR1;
            S_AR1: if (e_now >= CNT_W'(AR_T)) state_nxt = S_FG;
            S_FG: begin
                if ((e_now >= CNT_W'(F_MAX)) || ((e_now >= CNT_W'(F_MIN)) && !c_s)) begin
                    state_nxt = S_FY;
                end
            end
            S_FY:  if (e_now >= CNT_W'(Y_T))  state_nxt = S_AR2;
            S_AR2: if (e_now >= CNT_W'(AR_T)) state_nxt = S_HG;
            S_FLASH: begin
                if (!night) begin
                    state_nxt = S_AR2;
                end else if (e_now >= CNT_W'(FLASH_T)) begin
                    // half period elapsed: toggle phase and restart the count
                    flash_on_nxt = !flash_on;
                    e_nxt        = '0;
                end
            end
            default: state_nxt = S_HG;
        endcase

        if (state_nxt != state) begin
            e_nxt        = '0;
            presc_nxt    = '0;
            flash_on_nxt = 1'b1;
        end

        // Pending request is cleared on FG entry and not re-armed while FG runs
        ped_pending_nxt = ped_pending | ped_req;
        if ((state_nxt == S_FG) || (state == S_FG)) begin
            ped_pending_nxt = 1'b0;
        end

        case (state_nxt)
            S_HG:    hl_nxt = LAMP_G;
            S_HY:    hl_nxt = LAMP_Y;
            S_FG:    fl_nxt = LAMP_G;
            S_FY:    fl_nxt = LAMP_Y;
            S_FLASH: begin
                hl_nxt = flash_on_nxt ? LAMP_Y : LAMP_OFF;
                fl_nxt = flash_on_nxt ? LAMP_R : LAMP_OFF;
            end
            default: begin
                hl_nxt = LAMP_R;
                fl_nxt = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk_125M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HG;
            elapsed     <= '0;
            presc       <= '0;
            flash_on    <= 1'b1;
            ped_pending <= 1'b0;
            c_meta      <= 1'b0;
            c_s         <= 1'b0;
            HL          <= LAMP_G;
            FL          <= LAMP_R;
            ped_walk    <= 1'b0;
        end else begin
            state       <= state_nxt;
            elapsed     <= e_nxt;
            presc       <= presc_nxt;
            flash_on    <= flash_on_nxt;
            ped_pending <= ped_pending_nxt;
            c_meta      <= c;
            c_s         <= c_meta;
            HL          <= hl_nxt;
            FL          <= fl_nxt;
            ped_walk    <= (state_nxt == S_FG);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Directed bench for traffic_light_ctrl_p at default parameters (TICK_DIV=1).
module tb_traffic_light_ctrl_p;

    logic       clk_125M = 1'b0;
    logic       rst_n;
    logic       c, ped_req, night;
    logic [2:0] HL, FL, state_o;
    logic       ped_walk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       c;
        logic       ped;
        logic       night;
        int         wait_n;
        logic [2:0] st;
        logic [2:0] hl;
        logic [2:0] fl;
        logic       walk;
    } vec_t;

    vec_t vq[$];

    localparam logic [2:0] HG = 3'd0, HY = 3'd1, AR1 = 3'd2, FG = 3'd3, FY = 3'd4, AR2 = 3'd5, FLS = 3'd6;

    traffic_light_ctrl_p dut (
        .clk_125M (clk_125M),
        .rst_n    (rst_n),
        .c        (c),
        .ped_req  (ped_req),
        .night    (night),
        .HL       (HL),
        .FL       (FL),
        .ped_walk (ped_walk),
        .state_o  (state_o)
    );

    always #4 clk_125M = ~clk_125M;

    task automatic adv(input int n);
        repeat (n) @(posedge clk_125M);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [2:0] hl,
                         input logic [2:0] fl, input logic walk);
        checks++;
        if ({state_o, HL, FL, ped_walk} !== {st, hl, fl, walk}) begin
            errors++;
            $display("FAIL %s: got state=%0d HL=%b FL=%b walk=%b, expected state=%0d HL=%b FL=%b walk=%b",
                     name, state_o, HL, FL, ped_walk, st, hl, fl, walk);
        end
    endtask

    task automatic add(input logic cc, input logic pp, input logic nn, input int w,
                       input logic [2:0] st, input logic [2:0] hl, input logic [2:0] fl, input logic wk);
        vec_t v;
        v = '{c: cc, ped: pp, night: nn, wait_n: w, st: st, hl: hl, fl: fl, walk: wk};
        vq.push_back(v);
    endtask

    // Lamp safety outside flash mode: at least one road shows red
    always @(negedge clk_125M) begin
        if (rst_n === 1'b1 && state_o != FLS) begin
            checks++;
            if (!HL[2] && !FL[2]) begin
                errors++;
                $display("FAIL safety: HL=%b FL=%b state=%0d, expected one road red", HL, FL, state_o);
            end
        end
    end

    initial begin
        rst_n = 1'b0; c = 1'b0; ped_req = 1'b0; night = 1'b0;

        // c,ped,night,wait, state, HL, FL, walk
        add(1,0,0, 2, HG,  3'b001,3'b100,0);
        add(1,0,0, 1, HY,  3'b010,3'b100,0);
        add(1,0,0, 2, HY,  3'b010,3'b100,0);
        add(1,0,0, 1, AR1, 3'b100,3'b100,0);
        add(1,0,0, 1, FG,  3'b100,3'b001,1);
        add(1,0,0,19, FG,  3'b100,3'b001,1);
        add(1,0,0, 1, FY,  3'b100,3'b010,0);
        add(1,0,0, 3, AR2, 3'b100,3'b100,0);
        add(0,0,0, 1, HG,  3'b001,3'b100,0);
        add(1,0,0, 9, HG,  3'b001,3'b100,0);
        add(1,0,0, 1, HY,  3'b010,3'b100,0);
        add(1,0,0, 4, FG,  3'b100,3'b001,1);
        add(0,0,0, 4, FG,  3'b100,3'b001,1);
        add(0,0,0, 1, FY,  3'b100,3'b010,0);
        add(0,0,0, 3, AR2, 3'b100,3'b100,0);
        add(0,0,0, 1, HG,  3'b001,3'b100,0);
        add(0,0,0, 2, HG,  3'b001,3'b100,0);
        add(0,1,0, 1, HG,  3'b001,3'b100,0);
        add(0,0,0, 6, HG,  3'b001,3'b100,0);
        add(0,0,0, 1, HY,  3'b010,3'b100,0);
        add(0,0,0, 4, FG,  3'b100,3'b001,1);
        add(0,0,0, 4, FG,  3'b100,3'b001,1);
        add(0,0,0, 1, FY,  3'b100,3'b010,0);
        add(0,0,0, 4, HG,  3'b001,3'b100,0);
        add(0,0,0,15, HG,  3'b001,3'b100,0);
        add(0,0,1, 1, FLS, 3'b010,3'b100,0);
        add(0,0,1, 3, FLS, 3'b010,3'b100,0);
        add(0,0,1, 1, FLS, 3'b000,3'b000,0);
        add(0,0,1, 3, FLS, 3'b000,3'b000,0);
        add(0,0,1, 1, FLS, 3'b010,3'b100,0);
        add(0,0,0, 1, AR2, 3'b100,3'b100,0);
        add(0,0,0, 1, HG,  3'b001,3'b100,0);
        add(1,0,0, 9, HG,  3'b001,3'b100,0);
        add(1,0,0, 1, HY,  3'b010,3'b100,0);

        #10;
        check("reset", HG, 3'b001, 3'b100, 0);
        @(negedge clk_125M);
        rst_n = 1'b1;
        adv(1);

        for (int i = 0; i < 200; i++) begin
            check("idle", HG, 3'b001, 3'b100, 0);
            adv(1);
        end

        foreach (vq[i]) begin
            c = vq[i].c; ped_req = vq[i].ped; night = vq[i].night;
            adv(vq[i].wait_n);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].hl, vq[i].fl, vq[i].walk);
        end

        // Night raised during FG: cycle completes to HG, then flashes
        adv(4);
        check("night_fg", FG, 3'b100, 3'b001, 1);
        c = 1'b0; night = 1'b1;
        adv(5);
        check("night_fy", FY, 3'b100, 3'b010, 0);
        adv(4);
        check("night_hg", HG, 3'b001, 3'b100, 0);
        adv(1);
        check("night_flash", FLS, 3'b010, 3'b100, 0);
        night = 1'b0;
        adv(1);
        check("night_ar2", AR2, 3'b100, 3'b100, 0);
        adv(1);
        check("night_back", HG, 3'b001, 3'b100, 0);

        // Asynchronous reset mid-FG
        c = 1'b1;
        adv(14);
        check("pre_rst_fg", FG, 3'b100, 3'b001, 1);
        #2 rst_n = 1'b0;
        #1 check("async_rst", HG, 3'b001, 3'b100, 0);
        #1 rst_n = 1'b1;
        adv(9);
        check("rst_gmin_hold", HG, 3'b001, 3'b100, 0);
        adv(1);
        check("rst_gmin_hy", HY, 3'b010, 3'b100, 0);

        // ped_req on FG entry edge and during FG must not latch
        c = 1'b0;
        adv(3);
        ped_req = 1'b1;
        adv(1);
        check("ped_entry_fg", FG, 3'b100, 3'b001, 1);
        ped_req = 1'b0;
        adv(2);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        adv(2);
        check("ped_fy", FY, 3'b100, 3'b010, 0);
        adv(4);
        check("ped_hg", HG, 3'b001, 3'b100, 0);
        adv(15);
        check("ped_no_relatch", HG, 3'b001, 3'b100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
